// File: rtl/jam_cost_table.sv
// Cost-table front end for the JAM solver: streams in an 8x8 table of 7-bit costs, serves registered
// lookups, gates the solver reset and captures its result. Optional running checksum: JAM_COST_CHECKSUM_EN.
module jam_cost_table (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [6:0]  in_data,
  output logic        in_ready,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  output logic        JamRst,
  output logic        Loaded,
  input  logic        Valid,
  input  logic [3:0]  MatchCount,
  input  logic [9:0]  MinCost,
  output logic        ResValid,
  output logic [3:0]  ResMatch,
`ifdef JAM_COST_CHECKSUM_EN
  output logic [9:0]  ResMin,
  output logic [12:0] Checksum
`else
  output logic [9:0]  ResMin
`endif
);

  typedef enum logic {LOAD, RUN} state_e;

  state_e      state_q, state_d;
  logic [5:0]  wcnt_q, wcnt_d;
  logic [6:0]  cost_q;
  logic        jam_rst_q, jam_rst_d;
  logic        loaded_q, loaded_d;
  logic        res_valid_q, res_valid_d;
  logic [3:0]  res_match_q, res_match_d;
  logic [9:0]  res_min_q, res_min_d;
  logic        accept;
  logic [6:0]  mem [64];

  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid & in_ready;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    res_valid_d = 1'b0;
    res_match_d = res_match_q;
    res_min_d   = res_min_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          wcnt_d = wcnt_q + 6'd1;
          if (wcnt_q == 6'd63) state_d = RUN;
        end
      end
      RUN: begin
        if (Valid) begin
          state_d     = LOAD;
          res_valid_d = 1'b1;
          res_match_d = MatchCount;
          res_min_d   = MinCost;
        end
      end
      default: state_d = LOAD;
    endcase
    jam_rst_d = (state_d != RUN);
    loaded_d  = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only; the table contents are deliberately
  // left out of the reset branch (large storage needs no reset), so writes are suppressed while RST is high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= LOAD;
      wcnt_q      <= 6'd0;
      cost_q      <= 7'd0;
      jam_rst_q   <= 1'b1;
      loaded_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 4'd0;
      res_min_q   <= 10'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      cost_q      <= mem[{W, J}];
      jam_rst_q   <= jam_rst_d;
      loaded_q    <= loaded_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_min_q   <= res_min_d;
      if (accept) mem[wcnt_q] <= in_data;
    end
  end

  assign Cost     = cost_q;
  assign JamRst   = jam_rst_q;
  assign Loaded   = loaded_q;
  assign ResValid = res_valid_q;
  assign ResMatch = res_match_q;
  assign ResMin   = res_min_q;

`ifdef JAM_COST_CHECKSUM_EN
  logic [12:0] checksum_q, checksum_d;

  // The first word of each load restarts the sum instead of adding to the previous table's total.
  always_comb begin
    checksum_d = checksum_q;
    if (accept) begin
      if (wcnt_q == 6'd0) checksum_d = {6'd0, in_data};
      else                checksum_d = checksum_q + {6'd0, in_data};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) checksum_q <= 13'd0;
    else     checksum_q <= checksum_d;
  end

  assign Checksum = checksum_q;
`endif

endmodule

// File: doc/jam_cost_table.md
# jam_cost_table

Cost-table front end for the JAM job-assignment solver. Accepts the 8×8 worker/job cost matrix from a host over a valid/ready stream, stores it, and serves the solver's `(W, J)` lookups with a registered `Cost`. Holds the solver in reset until the table is complete. Captures the solver's `MatchCount`/`MinCost` result when the solver signals `Valid`, then re-arms for the next matrix.

## Interface
Parameters: none (geometry fixed at 8×8, 7-bit costs).
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: host cost word valid.
- `in_data` in 7: cost word, row-major (entry k: W=k[5:3], J=k[2:0]).
- `in_ready` out 1: table accepting words; high iff state LOAD.
- `W` in 3: solver row (worker) address.
- `J` in 3: solver column (job) address.
- `Cost` out 7: registered read data for previous cycle's `{W,J}`.
- `JamRst` out 1: synchronous reset to the solver, high outside RUN.
- `Loaded` out 1: high while in RUN.
- `Valid` in 1: solver result strobe.
- `MatchCount` in 4: solver match count.
- `MinCost` in 10: solver minimum cost.
- `ResValid` out 1: one-cycle pulse, result captured.
- `ResMatch` out 4: captured MatchCount.
- `ResMin` out 10: captured MinCost.
- `Checksum` out 13: present only with `JAM_COST_CHECKSUM_EN`.

## Operation
- Storage: 64×7 array, no reset on contents. Write index = 6-bit load counter `wcnt`.
- States: LOAD, RUN.
- LOAD: `in_ready`=1. Accept = `in_valid & in_ready`. Each accept writes `mem[wcnt] <= in_data`, `wcnt <= wcnt+1`. Accept with `wcnt==63` → RUN next edge; `wcnt` wraps to 0. `Valid` ignored in LOAD.
- RUN: `in_ready`=0, `in_valid`/`in_data` ignored. Sampling `Valid`=1 → capture `ResMatch<=MatchCount`, `ResMin<=MinCost`, `ResValid<=1` for exactly one cycle, → LOAD next edge.
- Read port active in every state: `Cost <= mem[{W,J}]` each edge. Same-address write and read in one cycle returns the old data.
- `JamRst`, `Loaded` registered, updated on the same edge as the state: `JamRst` = (next state != RUN), `Loaded` = (next state == RUN).

## Timing
- Reset values: state LOAD, `wcnt`=0, `in_ready`=1, `Cost`=0, `JamRst`=1, `Loaded`=0, `ResValid`=0, `ResMatch`=0, `ResMin`=0, `Checksum`=0.
- No write occurs while `RST` is high.
- Read latency: 1 cycle. `{W,J}` presented in cycle n → `Cost` valid in cycle n+1.
- Load-done latency: the edge that accepts entry 63 sets `Loaded`=1 and `JamRst`=0. The solver runs from the following cycle.
- Result latency: `Valid` sampled high at edge e → at edge e: `ResValid`=1, state LOAD, `JamRst`=1, `in_ready`=1. At edge e+1: `ResValid`=0.
- Back-to-back accepts at one word per cycle; gaps (`in_valid`=0) hold `wcnt`.
- Reset mid-load: `wcnt` cleared, and a full 64-word reload is required. Stale memory contents are then overwritten.
- Reset mid-run: returns to LOAD. No `ResValid` is produced.
- `Valid` held high for several cycles: only the first cycle in RUN captures. The following cycles fall in LOAD and are ignored.

## Configuration
- `JAM_COST_CHECKSUM_EN` defined:
  - 13-bit `Checksum` output; maximum sum is 64×127 = 8128, so no overflow.
  - Cleared on the first accept of a load (`wcnt`==0), so the first word's value is loaded directly rather than added.
  - Accumulates `in_data` on every accept.
  - Holds its value through RUN.
- Undefined: `Checksum` port and its adder are absent; all other behaviour is identical.

## Test plan
- Reset then stream `in_data=8*W+J mod 128` (values 0..63), no gaps → after the 64th accept: `Loaded`=1, `JamRst`=0, `in_ready`=0. Then drive W=3, J=5 → `Cost`=29 in the next cycle.
- Load with a random `in_valid` duty cycle (~50%) → exactly 64 accepts before `Loaded`=1. Read-back of all 64 addresses matches the written values.
- In RUN, pulse `Valid` with `MatchCount`=3, `MinCost`=100 → one-cycle `ResValid`, `ResMatch`=3, `ResMin`=100. Same edge: `JamRst`=1, `in_ready`=1.
- Assert `RST` after 30 accepts, release, stream 64 new words (all 7) → `Loaded` only after the 64th new word. Every read returns 7.
- In RUN, drive `in_valid`=1 with `in_data`=0 for 10 cycles → memory unchanged, `in_ready`=0. `Valid` pulsed in LOAD → no `ResValid`.
- With `JAM_COST_CHECKSUM_EN`, load pattern 0..63 → `Checksum`=2016. Reload all 127 → `Checksum`=8128.
